// File: rtl/serie_paralelo_8b_pkg.sv
// rtl/serie_paralelo_8b_pkg.sv - shared state encodings and line symbols for the serial link
package serie_paralelo_8b_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

    // Also used by the parallel->serial transmit side as its idle symbol.
    localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

endpackage

// File: rtl/serie_paralelo_8b_com_detect.sv
// rtl/serie_paralelo_8b_com_detect.sv - 8-bit sliding window, COM comparator and byte boundary flag
module serie_paralelo_8b_com_detect
    import serie_paralelo_8b_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
    input  logic [6:0] shift,
    input  logic       data_in,
    input  logic [2:0] bit_cnt,
    output logic [7:0] window,
    output logic       is_com,
    output logic       boundary
);

    assign window   = {shift, data_in};
    assign is_com   = (window == COM_SYMBOL);
    assign boundary = (bit_cnt == 3'd7);

endmodule

// File: rtl/serie_paralelo_8b.sv
// rtl/serie_paralelo_8b.sv - serial to byte deserialiser with COM alignment; SP_IDLE_COUNT_EN adds idle_cnt
module serie_paralelo_8b
    import serie_paralelo_8b_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int         COM_COUNT  = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SP_IDLE_COUNT_EN
    ,
    output logic [7:0] idle_cnt
`endif
);

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    sp_state_t  state, state_nxt;
    logic [6:0] shift;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [3:0] com_cnt, com_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic [7:0] window;
    logic       is_com;
    logic       boundary;

    serie_paralelo_8b_com_detect #(
        .COM_SYMBOL (COM_SYMBOL)
    ) u_com_detect (
        .shift    (shift),
        .data_in  (data_in),
        .bit_cnt  (bit_cnt),
        .window   (window),
        .is_com   (is_com),
        .boundary (boundary)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            shift     <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= window[6:0];
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        data_nxt    = data_out;
        valid_nxt   = valid_out;
        case (state)
            SEARCH: begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
                if (is_com) begin
                    bit_cnt_nxt = '0;
                    com_cnt_nxt = 4'd1;
                    state_nxt   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                data_nxt    = '0;
                valid_nxt   = 1'b0;
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary) begin
                    // A non-COM boundary drops back to bit sliding without losing the current bit history.
                    if (is_com) begin
                        com_cnt_nxt = com_cnt + 4'd1;
                        if (com_cnt + 4'd1 == COM_TARGET) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        com_cnt_nxt = '0;
                        state_nxt   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary) begin
                    data_nxt  = is_com ? 8'h00 : window;
                    valid_nxt = !is_com;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    assign active = (state == ACTIVE);

`ifdef SP_IDLE_COUNT_EN
    logic idle_hit;

    assign idle_hit = (state == ACTIVE) && boundary && is_com;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (idle_hit && idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serie_paralelo_8b.sv
// tb/tb_serie_paralelo_8b.sv - scoreboard bench for serie_paralelo_8b (COM_COUNT 4 and 1 instances)
module tb_serie_paralelo_8b;

    typedef struct {
        logic [7:0] d;
        int         e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       din  [2];
    logic [7:0] dout [2];
    logic       vout [2];
    logic       act  [2];
`ifdef SP_IDLE_COUNT_EN
    logic [7:0] icnt [2];
`endif

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    logic rst_q   = 1'b0;
    int   run [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    serie_paralelo_8b u0 (
        .clk_32f   (clk),
        .reset     (reset),
        .data_in   (din[0]),
        .data_out  (dout[0]),
        .valid_out (vout[0]),
        .active    (act[0])
`ifdef SP_IDLE_COUNT_EN
        ,
        .idle_cnt  (icnt[0])
`endif
    );

    serie_paralelo_8b #(.COM_COUNT(1)) u1 (
        .clk_32f   (clk),
        .reset     (reset),
        .data_in   (din[1]),
        .data_out  (dout[1]),
        .valid_out (vout[1]),
        .active    (act[1])
`ifdef SP_IDLE_COUNT_EN
        ,
        .idle_cnt  (icnt[1])
`endif
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // Each valid stretch must be a whole number of 8-cycle byte slots; every slot start pops one expected byte.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            if (vout[i]) begin
                if (run[i] % 8 == 0) begin
                    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    chk($sformatf("valid_expected_u%0d", i), 32'(have), 32'd1);
                    if (have) begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("data_u%0d", i), 32'(dout[i]), 32'(e.d));
                        chk($sformatf("latency_u%0d", i), cyc, e.e);
                    end
                end
                run[i]++;
            end else begin
                if (run[i] % 8 != 0 && !rst_q) begin
                    chk($sformatf("hold_len_u%0d", i), run[i] % 8, 0);
                end
                run[i] = 0;
                chk($sformatf("idle_data_u%0d", i), 32'(dout[i]), 32'd0);
            end
        end
    end

    task automatic bit_tx(input int i, input logic b);
        din[i] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic byte_tx(input int i, input logic [7:0] b, input bit expect_out);
        exp_t e;
        for (int k = 7; k >= 0; k--) bit_tx(i, b[k]);
        if (expect_out) begin
            e.d = b;
            e.e = cyc;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic do_reset();
        din[0] = 1'b0;
        din[1] = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_data_u%0d", tag, i), 32'(dout[i]), 32'd0);
            chk($sformatf("%s_valid_u%0d", tag, i), 32'(vout[i]), 32'd0);
            chk($sformatf("%s_active_u%0d", tag, i), 32'(act[i]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] com;
        com    = 8'hBC;
        reset  = 1'b1;
        din[0] = 1'b0;
        din[1] = 1'b0;

        do_reset();
        check_zero("reset");

        // four COMs from the first bit
        for (int n = 0; n < 3; n++) byte_tx(0, com, 1'b0);
        chk("t1_active_after_3com", 32'(act[0]), 32'd0);
        byte_tx(0, com, 1'b0);
        chk("t1_active_after_4com", 32'(act[0]), 32'd1);

        // three bit offset before alignment
        do_reset();
        for (int n = 0; n < 3; n++) bit_tx(0, 1'b0);
        for (int n = 0; n < 4; n++) byte_tx(0, com, 1'b0);
        chk("t2_active", 32'(act[0]), 32'd1);
        byte_tx(0, 8'hA5, 1'b1);
        byte_tx(0, com, 1'b0);

        // broken COM run restarts the count
        do_reset();
        byte_tx(0, com, 1'b0);
        byte_tx(0, com, 1'b0);
        byte_tx(0, 8'h3C, 1'b0);
        chk("t3_active_after_3c", 32'(act[0]), 32'd0);
        for (int n = 0; n < 3; n++) byte_tx(0, com, 1'b0);
        chk("t3_active_after_3com", 32'(act[0]), 32'd0);
        byte_tx(0, com, 1'b0);
        chk("t3_active_after_4com", 32'(act[0]), 32'd1);

        // data, idle, data
        do_reset();
        for (int n = 0; n < 4; n++) byte_tx(0, com, 1'b0);
        byte_tx(0, 8'h11, 1'b1);
        byte_tx(0, com, 1'b0);
        chk("t4_idle_valid", 32'(vout[0]), 32'd0);
        byte_tx(0, 8'h22, 1'b1);
`ifdef SP_IDLE_COUNT_EN
        chk("t4_idle_cnt", 32'(icnt[0]), 32'd1);
`endif
        byte_tx(0, com, 1'b0);

        // reset mid-byte while a byte is being held
        byte_tx(0, 8'h77, 1'b1);
        bit_tx(0, 1'b1);
        bit_tx(0, 1'b0);
        bit_tx(0, 1'b1);
        reset  = 1'b1;
        din[0] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("t5_midreset");
`ifdef SP_IDLE_COUNT_EN
        chk("t5_idle_cnt_clear", 32'(icnt[0]), 32'd0);
`endif
        for (int n = 0; n < 3; n++) byte_tx(0, com, 1'b0);
        chk("t5_active_after_3com", 32'(act[0]), 32'd0);
        byte_tx(0, com, 1'b0);
        chk("t5_active_after_4com", 32'(act[0]), 32'd1);
        byte_tx(0, 8'h3C, 1'b1);
        byte_tx(0, com, 1'b0);

        // COM_COUNT = 1 instance
        do_reset();
        byte_tx(1, com, 1'b0);
        chk("t6_active_u1", 32'(act[1]), 32'd1);
        chk("t6_active_u0", 32'(act[0]), 32'd0);
        byte_tx(1, 8'h5A, 1'b1);
        byte_tx(1, com, 1'b0);

        #6;
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
